// File: rtl/led_sel_ctrl_if.sv
// rtl/led_sel_ctrl_if.sv - button and select signal bundle for led_sel_ctrl
//
// Ports carried:
//   btn_up, btn_down, btn_mode : raw asynchronous active-high push-buttons
//   sel[1:0]                   : registered select to the 2-to-4 LED decoder
//   auto_mode                  : 1 while the controller scans automatically
//   sel_changed                : one-cycle pulse after sel takes a new value
// slave  = the controller (consumes buttons, drives select outputs)
// master = the button/decoder side (drives buttons, observes outputs)

interface led_sel_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_mode;
    logic [1:0] sel;
    logic       auto_mode;
    logic       sel_changed;

    modport master (
        output btn_up, btn_down, btn_mode,
        input  sel, auto_mode, sel_changed
    );

    modport slave (
        input  btn_up, btn_down, btn_mode,
        output sel, auto_mode, sel_changed
    );
endinterface

// File: rtl/led_sel_ctrl.sv
// rtl/led_sel_ctrl.sv - debounced button select controller with auto scan
//
// Ports:
//   clk      : system clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : led_sel_ctrl_if.slave (buttons in, sel/auto_mode/sel_changed out)
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronized cycles needed to accept a level (>= 2)
//   SCAN_TICKS      : clk cycles per automatic step in AUTO mode (>= 2)

module led_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SCAN_TICKS      = 50_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    led_sel_ctrl_if.slave   bus
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(SCAN_TICKS - 1);

    // Button index within the per-button vectors
    localparam int B_UP   = 0;
    localparam int B_DOWN = 1;
    localparam int B_MODE = 2;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    sync2_q, sync2_d;
    logic [2:0]    deb_q, deb_d;
    logic [2:0]    deb_prev_q, deb_prev_d;
    logic [2:0]    press_q, press_d;
    logic [DW-1:0] dcnt_q [3];
    logic [DW-1:0] dcnt_d [3];

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    sel_q, sel_d;
    logic          auto_q, auto_d;
    logic          chg_q, chg_d;

    logic          up_p, dn_p, md_p;
    logic          terminal;
    logic          auto_step;

    assign raw = {bus.btn_mode, bus.btn_down, bus.btn_up};

    // Synchronize, debounce and edge-detect each button
    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        press_d    = deb_q & ~deb_prev_q;
        for (int b = 0; b < 3; b++) begin
            dcnt_d[b] = '0;
            if (sync2_q[b] != deb_q[b]) begin
                if (dcnt_q[b] == DCNT_MAX) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    dcnt_d[b] = dcnt_q[b] + DW'(1);
                end
            end
        end
    end

    assign up_p     = press_q[B_UP];
    assign dn_p     = press_q[B_DOWN];
    assign md_p     = press_q[B_MODE];
    assign terminal = (tick_q == TICK_MAX);

    // A mode press or any manual press suppresses the auto step of that cycle
    assign auto_step = (state_q == AUTO) && terminal && !md_p && !up_p && !dn_p;

    // Mode FSM, tick counter and select update
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        sel_d   = sel_q;

        case (state_q)
            MANUAL: begin
                tick_d = '0;
                if (md_p) begin
                    state_d = AUTO;
                end
            end
            AUTO: begin
                if (md_p) begin
                    state_d = MANUAL;
                    tick_d  = '0;
                end else if (up_p || dn_p || terminal) begin
                    // Manual presses restart the scan period
                    tick_d = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = MANUAL;
                tick_d  = '0;
            end
        endcase

        if (up_p && dn_p) begin
            sel_d = sel_q;
        end else if (up_p) begin
            sel_d = sel_q + 2'd1;
        end else if (dn_p) begin
            sel_d = sel_q - 2'd1;
        end else if (auto_step) begin
            sel_d = sel_q + 2'd1;
        end

        auto_d = (state_d == AUTO);
        chg_d  = (sel_d != sel_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            for (int b = 0; b < 3; b++) begin
                dcnt_q[b] <= '0;
            end
            state_q    <= MANUAL;
            tick_q     <= '0;
            sel_q      <= 2'b00;
            auto_q     <= 1'b0;
            chg_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            press_q    <= press_d;
            for (int b = 0; b < 3; b++) begin
                dcnt_q[b] <= dcnt_d[b];
            end
            state_q    <= state_d;
            tick_q     <= tick_d;
            sel_q      <= sel_d;
            auto_q     <= auto_d;
            chg_q      <= chg_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.auto_mode   = auto_q;
    assign bus.sel_changed = chg_q;

endmodule

// File: doc/led_sel_ctrl.md
# led_sel_ctrl

Button-driven select controller that sits directly upstream of the 2-to-4 LED decoder and drives its 2-bit select input. It synchronizes and debounces three raw push-buttons and keeps a wrapping 2-bit select register. Up/down buttons step the select in MANUAL mode. In AUTO mode the select also advances on a periodic tick, so the decoder scans the four LEDs.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive synchronized-stable cycles required to accept a button level (10 ms at 100 MHz); must be ≥ 2
- SCAN_TICKS, 50_000_000: clk cycles per automatic step in AUTO mode (0.5 s at 100 MHz); must be ≥ 2
- clk  input  1  system clock; all state on rising edge
- reset_n  input  1  one clock; reset is asynchronous and active-low
- btn_up  input  1  raw, asynchronous, active-high button; increment select
- btn_down  input  1  raw, asynchronous, active-high button; decrement select
- btn_mode  input  1  raw, asynchronous, active-high button; toggle MANUAL/AUTO
- sel  output  2  select to decoder input; registered
- auto_mode  output  1  1 = AUTO state; registered
- sel_changed  output  1  one-cycle pulse on the edge where sel takes a new value; registered

## Operation
- Per button, three stages:
  - 2-FF synchronizer.
  - Debounce counter, width $clog2(DEBOUNCE_CYCLES). The counter clears whenever the synchronized level equals the debounced level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 with levels still differing, the debounced level takes the synchronized level and the counter clears.
  - Press pulse: registered 1-cycle pulse on each 0→1 transition of the debounced level.
- Releases produce no pulse. A bounce shorter than DEBOUNCE_CYCLES is discarded and resets the count.
- State machine has two states, MANUAL and AUTO.
  - A mode press toggles the state.
  - Entering either state clears the tick counter.
- Tick counter, width $clog2(SCAN_TICKS):
  - Runs only in AUTO.
  - Counts 0..SCAN_TICKS-1.
  - At terminal count it wraps to 0 and generates an auto step.
- Select update, evaluated each cycle in the order below:
  - up press and down press in the same cycle: no step, regardless of the auto step.
  - Up press only: sel ← sel+1, mod 4 (3→0).
  - Down press only: sel ← sel−1, mod 4 (0→3).
  - A manual press in AUTO also clears the tick counter, and any auto step in that cycle is suppressed.
  - Otherwise an auto step gives sel ← sel+1, mod 4.
- A mode press coincident with an up or down press: the mode toggles and the step is still applied.
- A mode press coincident with a terminal tick in AUTO: the state becomes MANUAL and no auto step occurs.
- sel_changed = 1 for exactly the cycle after any register update that changed sel. It is never asserted for net-zero events.

## Timing
- Reset (reset_n low, asynchronous):
  - sel = 2'b00, auto_mode = 0, sel_changed = 0.
  - Synchronizers, debounced levels, debounce counters, press pulses and tick counter all = 0.
  - State = MANUAL.
- A reset mid-debounce or mid-scan discards all progress. After release, operation restarts from the reset values with no spurious press.
- Press latency, counting edge 1 as the first rising clk edge sampling the raw button high, with the button held continuously:
  - Debounced level rises at edge DEBOUNCE_CYCLES+2.
  - Press pulse is high after edge DEBOUNCE_CYCLES+3.
  - sel and auto_mode update at edge DEBOUNCE_CYCLES+4.
  - sel_changed is high for the cycle following that edge.
- AUTO scan period is exactly SCAN_TICKS cycles between consecutive sel changes, absent manual presses.
- A manual press in AUTO restarts the period: the next auto step comes SCAN_TICKS cycles after the manual step.
- Outputs are glitch-free (direct register outputs). The decoder consumes sel combinationally.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SCAN_TICKS=8.
- Reset: hold reset_n low 3 cycles with all buttons high -> sel=0, auto_mode=0, sel_changed=0 throughout and for 5 cycles after release with buttons low.
- Clean press: btn_up high for 10 cycles from sel=0 -> sel=1 at exactly edge 8 after first sample, with a single sel_changed pulse. Release produces no further change. Four presses walk sel 1,2,3,0 (wrap).
- Bounce rejection: btn_down toggled high 3 cycles / low 1 cycle, repeated 5 times -> no change to sel or sel_changed. Then held 6 cycles from sel=0 -> sel=3.
- AUTO scan: press btn_mode -> auto_mode=1. sel then increments every 8 cycles: 0,1,2,3,0. A second mode press -> auto_mode=0 and sel holds for 40 cycles.
- Manual in AUTO: press btn_up 3 cycles before an auto step -> sel steps once from the press and the pending auto step is skipped. Next auto step occurs 8 cycles after the manual step.
- Simultaneous: btn_up and btn_down rise together from sel=2 -> sel stays 2 with no sel_changed. btn_mode and btn_up rise together in MANUAL -> auto_mode=1 and sel=3 on the same edge.
